sdes_subkey_sequencer: RTL

- Sequential S-DES key schedule. Captures a 10-bit key and applies P10, LS-1 + P8 to get K1, then LS-2 + P8 to get K2.
- Streams the two subkeys to the round datapath over a valid/ready handshake.
- In encrypt mode the order is K1 then K2. In decrypt mode it is K2 then K1, so the same Feistel datapath can run in reverse.
- Sits between the key register/switch input and the fk round logic.

---
 rtl/sdes_subkey_sequencer_if.sv | 34 +++
 rtl/sdes_subkey_sequencer.sv | 139 +++++++++++++
 2 files changed

// File: rtl/sdes_subkey_sequencer_if.sv
// Subkey stream bundle between the S-DES key schedule (master) and the
// round datapath / key source (slave).
interface sdes_subkey_sequencer_if;
  logic       i_start;
  logic [9:0] i_key;
  logic       i_decrypt;
  logic [7:0] o_subkey;
  logic       o_valid;
  logic       i_ready;
  logic       o_last;
  logic       o_busy;

  modport master (
    input  i_start,
    input  i_key,
    input  i_decrypt,
    input  i_ready,
    output o_subkey,
    output o_valid,
    output o_last,
    output o_busy
  );

  modport slave (
    output i_start,
    output i_key,
    output i_decrypt,
    output i_ready,
    input  o_subkey,
    input  o_valid,
    input  o_last,
    input  o_busy
  );
endinterface

// File: rtl/sdes_subkey_sequencer.sv
// Sequential S-DES key schedule: P10, LS-1/P8 -> K1, LS-2/P8 -> K2, then
// streams the two subkeys (K1,K2 or K2,K1 for decrypt) over valid/ready.
module sdes_subkey_sequencer #(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic                           i_clk,
  input  logic                           i_rst,
  sdes_subkey_sequencer_if.master        bus
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    LOAD  = 3'd1,
    GEN1  = 3'd2,
    GEN2  = 3'd3,
    EMIT0 = 3'd4,
    EMIT1 = 3'd5
  } state_t;

  function automatic logic [9:0] p10(input logic [9:0] k);
    return {k[7], k[5], k[8], k[3], k[6], k[0], k[9], k[1], k[2], k[4]};
  endfunction

  function automatic logic [7:0] p8(input logic [9:0] v);
    return {v[4], v[7], v[3], v[6], v[2], v[5], v[0], v[1]};
  endfunction

  function automatic logic [9:0] ls1(input logic [9:0] v);
    return {v[8:5], v[9], v[3:0], v[4]};
  endfunction

  function automatic logic [9:0] ls2(input logic [9:0] v);
    return {v[7:5], v[9:8], v[2:0], v[4:3]};
  endfunction

  state_t     state_r;
  state_t     state_next;
  logic [9:0] s_r;
  logic [7:0] k1_r;
  logic [7:0] k2_r;
  logic       dec_r;
  logic [7:0] subkey_r;
  logic       valid_r;
  logic       last_r;
  logic       busy_r;
  logic       hs;

  assign hs = valid_r && bus.i_ready;

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next;
    end
  end

  // Next-state logic; the key schedule always walks LOAD/GEN1/GEN2 in order.
  always_comb begin
    state_next = state_r;
    case (state_r)
      IDLE: begin
        if (bus.i_start) state_next = LOAD;
        else             state_next = IDLE;
      end
      LOAD:  state_next = GEN1;
      GEN1:  state_next = GEN2;
      GEN2:  state_next = EMIT0;
      EMIT0: begin
        if (hs) state_next = EMIT1;
        else    state_next = EMIT0;
      end
      EMIT1: begin
        if (hs) state_next = IDLE;
        else    state_next = EMIT1;
      end
      default: state_next = IDLE;
    endcase
  end

  // Key schedule datapath and registered outputs (decoded from next state so
  // nothing reaches the ports combinationally from i_ready or i_start).
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s_r      <= 10'd0;
      k1_r     <= 8'd0;
      k2_r     <= 8'd0;
      dec_r    <= 1'b0;
      subkey_r <= 8'd0;
      valid_r  <= 1'b0;
      last_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      valid_r <= (state_next == EMIT0) || (state_next == EMIT1);
      last_r  <= (state_next == EMIT1);
      busy_r  <= (state_next != IDLE);
      case (state_r)
        IDLE: begin
          if (bus.i_start) begin
            s_r   <= p10(bus.i_key);
            dec_r <= bus.i_decrypt;
          end
        end
        LOAD: s_r <= ls1(s_r);
        GEN1: begin
          k1_r <= p8(s_r);
          s_r  <= ls2(s_r);
        end
        GEN2: begin
          // K2 is still being written, so the first decrypt beat comes from P8 directly.
          k2_r     <= p8(s_r);
          subkey_r <= dec_r ? p8(s_r) : k1_r;
        end
        EMIT0: begin
          if (hs) subkey_r <= dec_r ? k1_r : k2_r;
        end
        EMIT1: begin
          if (hs && ZEROIZE) begin
            s_r      <= 10'd0;
            k1_r     <= 8'd0;
            k2_r     <= 8'd0;
            dec_r    <= 1'b0;
            subkey_r <= 8'd0;
          end
        end
        default: begin
          s_r <= s_r;
        end
      endcase
    end
  end

  assign bus.o_subkey = subkey_r;
  assign bus.o_valid  = valid_r;
  assign bus.o_last   = last_r;
  assign bus.o_busy   = busy_r;

endmodule
